// File: rtl/wide_reg_wb_master.sv
// Wishbone master moving one 128-bit value to/from a 32-bit slave as four word transactions.
// Define WIDE_XFER_TIMEOUT_EN to build the per-word ack timeout (TIMEOUT cycles).
module wide_reg_wb_master #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [127:0]          wdata_i,
    output logic [127:0]          rdata_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [3:0]            wb_sel_o,
    output logic [31:0]           wb_dat_o,
    input  logic [31:0]           wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    input  logic                  wb_stall_i
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StFinish} state_e;

    state_e                state_q, state_d;
    logic [1:0]            k_q, k_d;
    logic [127:0]          wsh_q, wsh_d;
    logic [127:0]          shadow_q, shadow_d;
    logic [127:0]          rdata_q, rdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  cyc_q, cyc_d;
    logic                  stb_q, stb_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [3:0]            sel_q;
    logic [127:0]          rd_shift;
    logic                  accept;
    logic                  word_done;
    logic                  timeout;
    logic                  abort;

    assign accept    = (state_q == StIssue) && !wb_stall_i;
    assign word_done = wb_ack_i && (accept || (state_q == StWait));
    // An ack arriving in the last allowed cycle still wins over the timeout.
    assign abort     = wb_err_i || (timeout && !word_done);

`ifdef WIDE_XFER_TIMEOUT_EN
    localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TmoW-1:0] tmo_q;

    assign timeout = ((state_q == StIssue) || (state_q == StWait)) &&
                     (tmo_q == TmoW'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmo_q <= '0;
        end else if (((state_q == StIssue) || (state_q == StWait)) && !word_done) begin
            tmo_q <= tmo_q + TmoW'(1);
        end else begin
            tmo_q <= '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        wsh_d    = wsh_q;
        shadow_d = shadow_q;
        rdata_d  = rdata_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        cyc_d    = cyc_q;
        stb_d    = stb_q;
        we_d     = we_q;
        adr_d    = adr_q;
        // Words arrive most-significant first, so shifting left lands word 0 in [127:96].
        rd_shift = {shadow_q[95:0], wb_dat_i};

        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    state_d = StIssue;
                    we_d    = we_i;
                    adr_d   = {addr_i[ADDR_WIDTH-1:4], 4'h0};
                    wsh_d   = wdata_i;
                    k_d     = 2'd0;
                    busy_d  = 1'b1;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                end
            end
            StIssue, StWait: begin
                if (abort) begin
                    state_d = StFinish;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else if (word_done) begin
                    if (!we_q) begin
                        shadow_d = rd_shift;
                    end
                    if (k_q == 2'd3) begin
                        state_d = StFinish;
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        if (!we_q) begin
                            rdata_d = rd_shift;
                        end
                    end else begin
                        state_d = StIssue;
                        stb_d   = 1'b1;
                        k_d     = k_q + 2'd1;
                        adr_d   = adr_q + ADDR_WIDTH'(4);
                        wsh_d   = {wsh_q[95:0], 32'h0};
                    end
                end else if (accept) begin
                    state_d = StWait;
                    stb_d   = 1'b0;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= StIdle;
            k_q      <= 2'd0;
            wsh_q    <= '0;
            shadow_q <= '0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            sel_q    <= 4'h0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            wsh_q    <= wsh_d;
            shadow_q <= shadow_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            sel_q    <= 4'hF;
        end
    end

    assign rdata_o  = rdata_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = stb_q;
    assign wb_we_o  = we_q;
    assign wb_adr_o = adr_q;
    assign wb_sel_o = sel_q;
    assign wb_dat_o = wsh_q[127:96];

endmodule

// File: tb/tb_wide_reg_wb_master.sv
// Self-checking bench for wide_reg_wb_master: behavioural Wishbone slave plus bus-word scoreboard.
module tb_wide_reg_wb_master;

    localparam int unsigned AW = 32;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          req_i;
    logic          we_i;
    logic [AW-1:0] addr_i;
    logic [127:0]  wdata_i;
    logic [127:0]  rdata_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic          wb_we_o;
    logic [AW-1:0] wb_adr_o;
    logic [3:0]    wb_sel_o;
    logic [31:0]   wb_dat_o;
    logic [31:0]   wb_dat_i   = 32'h0;
    logic          wb_ack_i   = 1'b0;
    logic          wb_err_i   = 1'b0;
    logic          wb_stall_i = 1'b0;

    always #5 clk_i = ~clk_i;

    wide_reg_wb_master #(.ADDR_WIDTH(AW), .TIMEOUT(64)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .req_i      (req_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .rdata_o    (rdata_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_sel_o   (wb_sel_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i),
        .wb_stall_i (wb_stall_i)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Slave configuration, written only by the test tasks.
    int          cfg_gen        = 0;
    bit          cfg_delay      = 1'b0;
    int          cfg_stall_word = -1;
    int          cfg_stall_len  = 0;
    int          cfg_err_word   = -1;
    bit          cfg_noack      = 1'b0;
    bit          cfg_spur       = 1'b0;
    logic [31:0] cfg_rd [4];

    // Slave state, written only by the slave process.
    int sl_gen     = 0;
    int acc_cnt    = 0;
    int stall_left = 0;
    bit pend       = 1'b0;
    int pend_idx   = 0;

    // Responses change on the falling edge; the DUT samples them on the next rising edge.
    always @(negedge clk_i) begin
        if (sl_gen != cfg_gen) begin
            sl_gen     <= cfg_gen;
            acc_cnt    <= 0;
            stall_left <= cfg_stall_len;
            pend       <= 1'b0;
            wb_ack_i   <= 1'b0;
            wb_err_i   <= 1'b0;
            wb_stall_i <= 1'b0;
            wb_dat_i   <= 32'h0;
        end else begin
            wb_ack_i   <= 1'b0;
            wb_err_i   <= 1'b0;
            wb_stall_i <= 1'b0;
            wb_dat_i   <= 32'h0;
            if (cfg_spur) begin
                wb_ack_i <= 1'b1;
                wb_err_i <= 1'b1;
                wb_dat_i <= 32'hDEAD_BEEF;
            end else if (pend) begin
                wb_ack_i <= 1'b1;
                wb_dat_i <= cfg_rd[pend_idx];
                pend     <= 1'b0;
            end else if (wb_cyc_o && wb_stb_o) begin
                if (acc_cnt == cfg_stall_word && stall_left > 0) begin
                    wb_stall_i <= 1'b1;
                    stall_left <= stall_left - 1;
                end else if (acc_cnt == cfg_err_word) begin
                    wb_err_i <= 1'b1;
                end else begin
                    acc_cnt <= acc_cnt + 1;
                    if (!cfg_noack) begin
                        if (cfg_delay) begin
                            pend     <= 1'b1;
                            pend_idx <= acc_cnt;
                        end else begin
                            wb_ack_i <= 1'b1;
                            wb_dat_i <= cfg_rd[acc_cnt];
                        end
                    end
                end
            end
        end
    end

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
    } bus_t;

    bus_t exp_q[$];

    task automatic slave_cfg(input bit delay, input int stall_word, input int stall_len,
                             input int err_word, input bit noack);
        cfg_delay      = delay;
        cfg_stall_word = stall_word;
        cfg_stall_len  = stall_len;
        cfg_err_word   = err_word;
        cfg_noack      = noack;
        cfg_spur       = 1'b0;
        cfg_gen        = cfg_gen + 1;
        @(negedge clk_i);
    endtask

    task automatic push_words(input logic we, input logic [31:0] base, input logic [127:0] data,
                              input int n);
        bus_t e;
        for (int k = 0; k < n; k++) begin
            e.adr = base + 32'(4 * k);
            e.dat = data[127 - 32 * k -: 32];
            e.we  = we;
            exp_q.push_back(e);
        end
    endtask

    // Drives req_i for one cycle; returns at the falling edge of the first stb cycle.
    task automatic start_req(input logic we, input logic [31:0] addr, input logic [127:0] data);
        @(negedge clk_i);
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = addr;
        wdata_i = data;
        @(negedge clk_i);
        req_i = 1'b0;
    endtask

    // Scoreboard pump: pops a bus word on each accepted stb until done_o or the cycle budget.
    // cyc counts cycles after the req cycle, so the req cycle itself is cycle 0.
    task automatic run_until_done(input int max_cyc, input bit junk_req, output int cyc,
                                  output int stall_cyc, output int err_cyc, output bit timed_out);
        bus_t e;
        cyc       = 1;
        stall_cyc = 0;
        err_cyc   = -1;
        timed_out = 1'b0;
        forever begin
            #1;
            if (done_o) break;
            if (cyc >= max_cyc) begin
                timed_out = 1'b1;
                break;
            end
            if (wb_stb_o && wb_stall_i) begin
                stall_cyc++;
                if (exp_q.size() > 0) begin
                    vectors++;
                    if (wb_adr_o !== exp_q[0].adr || wb_we_o !== exp_q[0].we ||
                        (exp_q[0].we && wb_dat_o !== exp_q[0].dat)) begin
                        miscompares++;
                        $display("FAIL stall_hold: adr=%h dat=%h, required adr=%h dat=%h",
                                 wb_adr_o, wb_dat_o, exp_q[0].adr, exp_q[0].dat);
                    end
                end
            end else if (wb_stb_o) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_word: adr=%h, required no bus word", wb_adr_o);
                end else begin
                    e = exp_q.pop_front();
                    if (wb_adr_o !== e.adr || wb_we_o !== e.we || wb_sel_o !== 4'hF ||
                        !wb_cyc_o || (e.we && wb_dat_o !== e.dat)) begin
                        miscompares++;
                        $display("FAIL bus_word: adr=%h dat=%h we=%b sel=%h, required adr=%h dat=%h we=%b sel=f",
                                 wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, e.adr, e.dat, e.we);
                    end
                end
            end
            if (wb_err_i && err_cyc < 0) err_cyc = cyc;
            @(negedge clk_i);
            cyc++;
            req_i = junk_req && (cyc == 2 || cyc == 3);
        end
        req_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        req_i   = 1'b0;
        we_i    = 1'b0;
        addr_i  = '0;
        wdata_i = '0;
        for (int i = 0; i < 4; i++) cfg_rd[i] = 32'h0;
        repeat (3) @(negedge clk_i);
        #1;
        vectors++;
        if ({busy_o, done_o, err_o, wb_cyc_o, wb_stb_o, wb_we_o} !== 6'b0 ||
            wb_adr_o !== '0 || wb_sel_o !== 4'h0 || wb_dat_o !== 32'h0 || rdata_o !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b done=%b err=%b cyc=%b stb=%b sel=%h rdata=%h, required all 0",
                     busy_o, done_o, err_o, wb_cyc_o, wb_stb_o, wb_sel_o, rdata_o);
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        #1;
        vectors++;
        if (wb_sel_o !== 4'hF || busy_o !== 1'b0 || wb_cyc_o !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset: sel=%h busy=%b cyc=%b, required sel=f busy=0 cyc=0",
                     wb_sel_o, busy_o, wb_cyc_o);
        end
    endtask

    task automatic test_write();
        int cyc, st, ec;
        bit to;
        bus_t e;
        slave_cfg(1'b0, -1, 0, -1, 1'b0);
        e = '{adr: 32'h40, dat: 32'h0011_2233, we: 1'b1}; exp_q.push_back(e);
        e = '{adr: 32'h44, dat: 32'h4455_6677, we: 1'b1}; exp_q.push_back(e);
        e = '{adr: 32'h48, dat: 32'h8899_AABB, we: 1'b1}; exp_q.push_back(e);
        e = '{adr: 32'h4C, dat: 32'hCCDD_EEFF, we: 1'b1}; exp_q.push_back(e);
        start_req(1'b1, 32'h47, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        run_until_done(50, 1'b0, cyc, st, ec, to);
        vectors++;
        // Counting the req cycle as the first, done_o lands in the sixth.
        if (to || cyc != 5 || err_o !== 1'b0 || busy_o !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL write_done: timeout=%b cyc=%0d err=%b busy=%b left=%0d, required 0 5 0 0 0",
                     to, cyc, err_o, busy_o, exp_q.size());
        end
        @(negedge clk_i);
        #1;
        vectors++;
        if (done_o !== 1'b0 || err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL write_pulse: done=%b err=%b one cycle later, required 0 0", done_o, err_o);
        end
    endtask

    task automatic test_read_delay();
        int cyc, st, ec;
        bit to;
        cfg_rd[0] = 32'hA0;
        cfg_rd[1] = 32'hB1;
        cfg_rd[2] = 32'hC2;
        cfg_rd[3] = 32'hD3;
        slave_cfg(1'b1, -1, 0, -1, 1'b0);
        push_words(1'b0, 32'h0, 128'h0, 4);
        start_req(1'b0, 32'h0, 128'h0);
        run_until_done(60, 1'b0, cyc, st, ec, to);
        vectors++;
        if (to || cyc != 9 || err_o !== 1'b0 ||
            rdata_o !== 128'h000000A0_000000B1_000000C2_000000D3) begin
            miscompares++;
            $display("FAIL read_delay: timeout=%b cyc=%0d err=%b rdata=%h, required 0 9 0 000000a0000000b1000000c2000000d3",
                     to, cyc, err_o, rdata_o);
        end
    endtask

    task automatic test_stall();
        int cyc, st, ec;
        bit to;
        slave_cfg(1'b0, 1, 3, -1, 1'b0);
        push_words(1'b1, 32'h40, 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE, 4);
        start_req(1'b1, 32'h40, 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE);
        run_until_done(60, 1'b0, cyc, st, ec, to);
        vectors++;
        if (to || st != 3 || cyc != 8 || err_o !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL stall_xfer: timeout=%b stalls=%0d cyc=%0d err=%b left=%0d, required 0 3 8 0 0",
                     to, st, cyc, err_o, exp_q.size());
        end
    endtask

    task automatic test_error();
        int cyc, st, ec;
        bit to;
        cfg_rd[0] = 32'h1111_1111;
        cfg_rd[1] = 32'h2222_2222;
        cfg_rd[2] = 32'h3333_3333;
        cfg_rd[3] = 32'h4444_4444;
        slave_cfg(1'b0, -1, 0, 2, 1'b0);
        push_words(1'b0, 32'h100, 128'h0, 3);
        start_req(1'b0, 32'h100, 128'h0);
        // Junk request presented while busy must not restart or redirect the transfer.
        we_i   = 1'b1;
        addr_i = 32'hF00;
        run_until_done(50, 1'b1, cyc, st, ec, to);
        vectors++;
        if (to || err_o !== 1'b1 || ec < 0 || cyc != ec + 1 || wb_cyc_o !== 1'b0 ||
            exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL err_abort: timeout=%b err=%b err_cyc=%0d done_cyc=%0d cyc_o=%b left=%0d, required err=1 done one cycle after err, cyc_o=0",
                     to, err_o, ec, cyc, wb_cyc_o, exp_q.size());
        end
        vectors++;
        if (rdata_o !== 128'h000000A0_000000B1_000000C2_000000D3) begin
            miscompares++;
            $display("FAIL err_rdata: rdata=%h, required 000000a0000000b1000000c2000000d3", rdata_o);
        end
        @(negedge clk_i);
        #1;
        vectors++;
        if (done_o !== 1'b0 || err_o !== 1'b0 || busy_o !== 1'b0 || wb_cyc_o !== 1'b0) begin
            miscompares++;
            $display("FAIL err_after: done=%b err=%b busy=%b cyc=%b, required all 0",
                     done_o, err_o, busy_o, wb_cyc_o);
        end
    endtask

    task automatic test_idle_ignore();
        slave_cfg(1'b0, -1, 0, -1, 1'b0);
        cfg_spur = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            #1;
            vectors++;
            if ({done_o, err_o, busy_o, wb_cyc_o} !== 4'b0) begin
                miscompares++;
                $display("FAIL idle_ignore: done=%b err=%b busy=%b cyc=%b, required all 0",
                         done_o, err_o, busy_o, wb_cyc_o);
            end
        end
        cfg_spur = 1'b0;
    endtask

    task automatic test_reset_mid();
        int cyc, st, ec;
        bit to;
        slave_cfg(1'b0, 1, 20, -1, 1'b0);
        start_req(1'b1, 32'h300, 128'h0);
        repeat (2) @(negedge clk_i);
        #1;
        vectors++;
        if (wb_adr_o !== 32'h304 || wb_stall_i !== 1'b1 || busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_word1: adr=%h stall=%b busy=%b, required 304 1 1",
                     wb_adr_o, wb_stall_i, busy_o);
        end
        #1;
        rst_n_i = 1'b0;
        #1;
        vectors++;
        if ({wb_cyc_o, wb_stb_o, busy_o, done_o, err_o} !== 5'b0 || rdata_o !== 128'h0) begin
            miscompares++;
            $display("FAIL async_reset: cyc=%b stb=%b busy=%b done=%b rdata=%h, required all 0",
                     wb_cyc_o, wb_stb_o, busy_o, done_o, rdata_o);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            #1;
            vectors++;
            if (done_o !== 1'b0 || wb_cyc_o !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold: done=%b cyc=%b, required 0 0", done_o, wb_cyc_o);
            end
        end
        rst_n_i = 1'b1;
        exp_q.delete();
        cfg_rd[0] = 32'h0BAD_F00D;
        cfg_rd[1] = 32'h1234_5678;
        cfg_rd[2] = 32'h9ABC_DEF0;
        cfg_rd[3] = 32'h5555_AAAA;
        slave_cfg(1'b0, -1, 0, -1, 1'b0);
        push_words(1'b0, 32'h80, 128'h0, 4);
        start_req(1'b0, 32'h8C, 128'h0);
        run_until_done(50, 1'b0, cyc, st, ec, to);
        vectors++;
        if (to || cyc != 5 || err_o !== 1'b0 ||
            rdata_o !== 128'h0BADF00D_12345678_9ABCDEF0_5555AAAA || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL reset_recover: timeout=%b cyc=%0d err=%b rdata=%h, required 0 5 0 0badf00d123456789abcdef05555aaaa",
                     to, cyc, err_o, rdata_o);
        end
    endtask

    task automatic test_timeout();
        int cyc, st, ec;
        bit to;
        slave_cfg(1'b0, -1, 0, -1, 1'b1);
        push_words(1'b1, 32'h200, 128'hCAFE0000_CAFE1111_CAFE2222_CAFE3333, 1);
        start_req(1'b1, 32'h200, 128'hCAFE0000_CAFE1111_CAFE2222_CAFE3333);
`ifdef WIDE_XFER_TIMEOUT_EN
        run_until_done(200, 1'b0, cyc, st, ec, to);
        vectors++;
        // Word 0 is accepted in cycle 1; the abort pulse lands 64 cycles later.
        if (to || cyc != 65 || err_o !== 1'b1 || wb_cyc_o !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_abort: timeout=%b cyc=%0d err=%b cyc_o=%b, required 0 65 1 0",
                     to, cyc, err_o, wb_cyc_o);
        end
`else
        run_until_done(1000, 1'b0, cyc, st, ec, to);
        vectors++;
        if (!to || busy_o !== 1'b1 || wb_cyc_o !== 1'b1 || err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL no_timeout: still_waiting=%b busy=%b cyc_o=%b err=%b, required 1 1 1 0",
                     to, busy_o, wb_cyc_o, err_o);
        end
`endif
        rst_n_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        exp_q.delete();
        slave_cfg(1'b0, -1, 0, -1, 1'b0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write();
        test_read_delay();
        test_stall();
        test_error();
        test_idle_ignore();
        test_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wide_reg_wb_master.md
# wide_reg_wb_master

Wishbone master that moves one 128-bit value to or from a 128-bit register on a 32-bit Wishbone slave, using four word transactions.
- The slave maps word offset 0 to bits [127:96] and offset 3 to bits [31:0].
- The block sits between a local requester (DMA engine, sequencer or test controller) and the register bank bus.
- It hides word splitting, stall handling and error/timeout recovery from the requester.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of addr_i and wb_adr_o (byte address).
- TIMEOUT, 64, maximum number of cycles one word may wait for ack (used only with WIDE_XFER_TIMEOUT_EN).

Ports:
- clk_i  in  1  single clock; all logic on rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- req_i  in  1  start request; sampled only when idle.
- we_i  in  1  1 = write wdata_i, 0 = read into rdata_o.
- addr_i  in  ADDR_WIDTH  base byte address; bits [3:0] are ignored and treated as 0.
- wdata_i  in  128  write data.
- rdata_o  out  128  last successfully read value.
- busy_o  out  1  transfer in progress.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle pulse, coincident with done_o, on failure.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone controls.
- wb_adr_o  out  ADDR_WIDTH  word address.
- wb_sel_o  out  4  constant 4'hF.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_ack_i, wb_err_i, wb_stall_i  in  1  slave responses.

## Operation
- States:
  - IDLE: accept a request.
  - ISSUE: stb asserted, waiting for stall low.
  - WAIT: stb low, waiting for ack.
  - FINISH: one cycle, pulses done.
- IDLE -> ISSUE when req_i = 1.
  - Latch we_i, addr_i & ~'hF, wdata_i; clear word counter k to 0.
  - busy_o goes high.
- Word k uses wb_adr_o = base + 4k and wb_dat_o = wdata[127-32k -: 32].
  - wb_cyc_o stays high from the first word through the last ack. No release between words.
- ISSUE: the word is accepted when wb_stb_o & ~wb_stall_i.
  - Accepted with no ack in the same cycle -> WAIT, and stb drops.
  - wb_ack_i in the same cycle as acceptance counts as completion of word k.
- Word completion on ack:
  - On a read, capture wb_dat_i into shadow[127-32k -: 32].
  - If k < 3: increment k and return to ISSUE with the next address.
  - If k = 3: go to FINISH.
- FINISH:
  - On a read, copy shadow to rdata_o.
  - Pulse done_o, then go to IDLE.
- Error: wb_err_i in ISSUE or WAIT aborts the transfer.
  - cyc and stb drop next cycle, followed by FINISH with err_o = 1.
  - rdata_o is not updated; it keeps its previous value.
- Ignored inputs:
  - req_i while busy_o is high.
  - ack or err when wb_cyc_o is low.
- Reset (async, any state):
  - State becomes IDLE; all outputs go to 0, including rdata_o = 128'h0 and wb_sel_o.
  - wb_sel_o always drives 4'hF after reset.
  - An in-flight bus cycle is abandoned at once, and no done_o is produced.

## Timing
- All outputs are registered.
- Latency from the req_i cycle:
  - wb_stb_o rises 1 cycle later.
  - A zero-wait slave (ack with stb, no stall) gives 4 consecutive stb cycles.
  - done_o follows 1 cycle after the 4th ack.
  - Total: 6 cycles from req_i to done_o.
- After each ack, the next word's stb is high in the following cycle, so there is zero idle gap.
- While stall is high, wb_adr_o, wb_dat_o and wb_we_o are held stable.
- done_o and err_o are high for exactly one cycle; busy_o falls in the same cycle as done_o.
- A new req_i is accepted in the cycle after done_o.

## Configuration
- Macro: WIDE_XFER_TIMEOUT_EN.
- Defined:
  - A per-word counter reloads at each new word and counts cycles in ISSUE and WAIT.
  - After TIMEOUT cycles without ack, the transfer aborts exactly as on wb_err_i (err_o = 1).
- Undefined:
  - No counter logic is built.
  - The master waits indefinitely for ack, and the TIMEOUT parameter is ignored.

## Test plan
- Write 128'h00112233_44556677_8899AABB_CCDDEEFF to addr 0x47 with a zero-wait slave -> 4 writes in order:
  - 0x40 with 0x00112233
  - 0x44 with 0x44556677
  - 0x48 with 0x8899AABB
  - 0x4C with 0xCCDDEEFF
  - wb_sel_o = 4'hF; done_o 6 cycles after req_i; err_o = 0.
- Read from base 0x0 with slave data 0xA0, 0xB1, 0xC2, 0xD3 and 1-cycle ack delay -> rdata_o = 128'h000000A0_000000B1_000000C2_000000D3 at done_o.
- Stall high for 3 cycles on word 1 -> adr/dat held at 0x44 value; the transfer still completes correctly.
- wb_err_i on word 2 of a read -> cyc low next cycle; done_o = err_o = 1; rdata_o keeps its prior value; req_i pulses while busy are ignored.
- With WIDE_XFER_TIMEOUT_EN and TIMEOUT = 64, no ack on word 0 -> err_o and done_o pulse 64 cycles after acceptance. Without the macro, no pulse after 1000 cycles.
- rst_n_i low during word 1 -> wb_cyc_o, busy_o and rdata_o are 0 immediately; no done_o; the next req_i works normally.
